fifo_uart_tx: RTL

- Consumer at the read end of the team's byte FIFO.
- Pops bytes with the FIFO's rd_en/empty/dout handshake and serialises each one as an asynchronous UART frame on `tx`: 1 start bit, 8 data bits LSB first, optional even parity, 1 or 2 stop bits.
- Sits between a transmit FIFO and the board-level serial pin.

---
 rtl/fifo_uart_tx.sv | 136 +++++++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fifo_uart_tx : pops bytes from a FIFO and sends them as 8-bit UART frames
// Revision     : 1.0
// ----------------------------------------------------------------------------
module fifo_uart_tx #(
  parameter int CLK_DIV   = 16,
  parameter int PARITY_EN = 0,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int             c_baud_w    = $clog2(CLK_DIV);
  localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLK_DIV - 1);
  localparam logic [2:0]     c_stop_last = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_LOAD   = 3'd2,
    S_START  = 3'd3,
    S_DATA   = 3'd4,
    S_PARITY = 3'd5,
    S_STOP   = 3'd6
  } state_t;

  state_t              r_state;
  logic [c_baud_w-1:0] r_baud;
  logic [2:0]          r_bit;
  logic [7:0]          r_shift;
  logic                r_parity;
  logic                r_tx;
  logic                r_done;

  logic w_bit_end;
  logic w_can_fetch;

  assign w_bit_end   = (r_baud == c_baud_last);
  assign w_can_fetch = enable && !fifo_empty;

  assign fifo_rd_en = (r_state == S_FETCH);
  assign busy       = (r_state != S_IDLE);
  assign tx         = r_tx;
  assign tx_done    = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE || r_state == S_FETCH || r_state == S_LOAD || w_bit_end)
        r_baud <= '0;
      else
        r_baud <= r_baud + 1'b1;

      case (r_state)
        S_IDLE: begin
          r_tx <= 1'b1;
          if (w_can_fetch) r_state <= S_FETCH;
        end
        S_FETCH: r_state <= S_LOAD;
        S_LOAD: begin
          r_shift  <= fifo_dout;
          r_parity <= ^fifo_dout;
          r_bit    <= '0;
          r_tx     <= 1'b0;
          r_state  <= S_START;
        end
        S_START: begin
          if (w_bit_end) begin
            r_tx    <= r_shift[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          // tx is registered, so the next bit is taken from shift[1] before shifting
          if (w_bit_end) begin
            r_shift <= r_shift >> 1;
            if (r_bit == 3'd7) begin
              r_bit <= '0;
              if (PARITY_EN != 0) begin
                r_tx    <= r_parity;
                r_state <= S_PARITY;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= r_shift[1];
            end
          end
        end
        S_PARITY: begin
          if (w_bit_end) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          // bit counter is reused to count stop bits
          if (w_bit_end) begin
            if (r_bit == c_stop_last) begin
              r_bit   <= '0;
              r_done  <= 1'b1;
              r_state <= w_can_fetch ? S_FETCH : S_IDLE;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        default: begin
          r_tx    <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
